// File: rtl/ahb_timer.sv
// 64-bit free-running timer with compare interrupt on a zero-wait-state AHB-Lite slave.
// Word-only register writes, any-size reads; COUNT_HI reads come from a shadow latched by a COUNT_LO read.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module ahb_timer #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hsel,
    input  logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
    input  logic                           hwrite,
    input  logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
    input  logic [`HASTI_BURST_WIDTH-1:0]  hburst,
    input  logic                           hmastlock,
    input  logic [`HASTI_PROT_WIDTH-1:0]   hprot,
    input  logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
    input  logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
    output logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
    output logic                           hready,
    output logic [`HASTI_RESP_WIDTH-1:0]   hresp,
    output logic                           irq
);

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_COUNT_LO = 3'd1;
    localparam logic [2:0] IDX_COUNT_HI = 3'd2;
    localparam logic [2:0] IDX_CMP_LO   = 3'd3;
    localparam logic [2:0] IDX_CMP_HI   = 3'd4;
    localparam logic [2:0] IDX_STATUS   = 3'd5;
    localparam logic [`HASTI_SIZE_WIDTH-1:0] SIZE_WORD = `HASTI_SIZE_WIDTH'(2);

    logic                      dp_valid;
    logic                      dp_write;
    logic                      dp_size_ok;
    logic [2:0]                dp_idx;

    logic                      ctrl_en;
    logic                      ctrl_irq_en;
    logic [PRESCALE_WIDTH-1:0] ctrl_prescale;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [63:0]               count;
    logic [63:0]               cmp;
    logic [31:0]               hi_shadow;
    logic                      pending;
    logic                      match_d;

    logic                      accept;
    logic                      wr_en;
    logic                      rd_count_lo;
    logic                      tick;
    logic                      match;
    logic [PRESCALE_WIDTH-1:0] presc_nxt;
    logic [63:0]               count_nxt;
    logic                      pending_nxt;
    logic                      irq_en_nxt;
    logic [31:0]               ctrl_word;
    logic [31:0]               wdata;

    assign hready = 1'b1;
    assign hresp  = '0;
    assign accept = hsel & htrans[1] & hready;
    assign wdata  = hwdata[31:0];
    assign wr_en  = dp_valid & dp_write & dp_size_ok;
    assign rd_count_lo = dp_valid & ~dp_write & (dp_idx == IDX_COUNT_LO);
    assign match  = (count >= cmp);

    logic unused_inputs;
    assign unused_inputs = ^{haddr[`HASTI_ADDR_WIDTH-1:5], haddr[1:0], hburst, hmastlock,
                             hprot, htrans[0], hwdata};

    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = ctrl_en;
        ctrl_word[1] = ctrl_irq_en;
        ctrl_word[8 +: PRESCALE_WIDTH] = ctrl_prescale;
    end

    always_comb begin
        tick      = 1'b0;
        presc_nxt = presc_cnt;
        if (ctrl_en) begin
            if (presc_cnt == ctrl_prescale) begin
                presc_nxt = '0;
                tick      = 1'b1;
            end else begin
                presc_nxt = presc_cnt + PRESCALE_WIDTH'(1);
            end
        end

        // A bus write to either half wins over the tick and suppresses the carry.
        count_nxt = tick ? count + 64'd1 : count;
        if (wr_en && dp_idx == IDX_COUNT_LO) count_nxt = {count[63:32], wdata};
        if (wr_en && dp_idx == IDX_COUNT_HI) count_nxt = {wdata, count[31:0]};

        pending_nxt = pending;
        if (wr_en && dp_idx == IDX_STATUS && wdata[0]) pending_nxt = 1'b0;
        if (match && !match_d) pending_nxt = 1'b1;

        irq_en_nxt = (wr_en && dp_idx == IDX_CTRL) ? wdata[1] : ctrl_irq_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid      <= 1'b0;
            dp_write      <= 1'b0;
            dp_size_ok    <= 1'b0;
            dp_idx        <= '0;
            ctrl_en       <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_prescale <= '0;
            presc_cnt     <= '0;
            count         <= '0;
            cmp           <= '1;
            hi_shadow     <= '0;
            pending       <= 1'b0;
            match_d       <= 1'b0;
            irq           <= 1'b0;
        end else begin
            dp_valid   <= accept;
            dp_write   <= accept & hwrite;
            dp_size_ok <= accept & (hsize == SIZE_WORD);
            dp_idx     <= accept ? haddr[4:2] : 3'd0;

            presc_cnt <= presc_nxt;
            count     <= count_nxt;
            pending   <= pending_nxt;
            match_d   <= match;
            irq       <= pending_nxt & irq_en_nxt;

            if (rd_count_lo) hi_shadow <= count[63:32];

            if (wr_en && dp_idx == IDX_CTRL) begin
                ctrl_en       <= wdata[0];
                ctrl_irq_en   <= wdata[1];
                ctrl_prescale <= wdata[8 +: PRESCALE_WIDTH];
            end
            if (wr_en && dp_idx == IDX_CMP_LO) cmp[31:0]  <= wdata;
            if (wr_en && dp_idx == IDX_CMP_HI) cmp[63:32] <= wdata;
        end
    end

    always_comb begin
        hrdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_idx)
                IDX_CTRL:     hrdata[31:0] = ctrl_word;
                IDX_COUNT_LO: hrdata[31:0] = count[31:0];
                IDX_COUNT_HI: hrdata[31:0] = hi_shadow;
                IDX_CMP_LO:   hrdata[31:0] = cmp[31:0];
                IDX_CMP_HI:   hrdata[31:0] = cmp[63:32];
                IDX_STATUS:   hrdata[0]    = pending;
                default:      hrdata       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_timer.sv
// Bench for ahb_timer: directed scenarios with literal expectations, then random bus traffic
// checked every cycle against a transaction-level model of the register file and timer.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module tb_ahb_timer;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          hsel;
    logic [`HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                          hwrite;
    logic [`HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [`HASTI_BURST_WIDTH-1:0] hburst;
    logic                          hmastlock;
    logic [`HASTI_PROT_WIDTH-1:0]  hprot;
    logic [`HASTI_TRANS_WIDTH-1:0] htrans;
    logic [`HASTI_BUS_WIDTH-1:0]   hwdata;
    logic [`HASTI_BUS_WIDTH-1:0]   hrdata;
    logic                          hready;
    logic [`HASTI_RESP_WIDTH-1:0]  hresp;
    logic                          irq;

    int checks = 0;
    int errors = 0;

    ahb_timer #(.PRESCALE_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
        .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers plus the one outstanding data phase.
    bit          model_live = 0;
    bit          m_en, m_irq_en;
    bit [7:0]    m_presc, m_pc;
    bit [63:0]   m_count, m_cmp;
    bit [31:0]   m_shadow, m_wd;
    bit          m_pending, m_hit_prev;
    bit          m_dv, m_dw, m_dsz;
    int          m_di;
    bit          hit, tick_now, clr_req;
    bit [63:0]   cnt_new;

    always @(posedge clk) begin
        if (reset) begin
            m_en = 0; m_irq_en = 0; m_presc = 0; m_pc = 0;
            m_count = 0; m_cmp = '1; m_shadow = 0; m_pending = 0; m_hit_prev = 0;
            m_dv = 0; m_dw = 0; m_dsz = 0; m_di = 0;
            model_live = 1;
        end else begin
            m_wd = hwdata[31:0];
            hit = (m_count >= m_cmp);
            tick_now = 0;
            if (m_en) begin
                if (m_pc == m_presc) begin m_pc = 0; tick_now = 1; end
                else m_pc = m_pc + 8'd1;
            end
            cnt_new = m_count + (tick_now ? 64'd1 : 64'd0);
            clr_req = 0;
            if (m_dv && !m_dw && m_di == 1) m_shadow = m_count[63:32];
            if (m_dv && m_dw && m_dsz) begin
                case (m_di)
                    0: begin m_en = m_wd[0]; m_irq_en = m_wd[1]; m_presc = m_wd[15:8]; end
                    1: cnt_new = {m_count[63:32], m_wd};
                    2: cnt_new = {m_wd, m_count[31:0]};
                    3: m_cmp[31:0] = m_wd;
                    4: m_cmp[63:32] = m_wd;
                    5: clr_req = m_wd[0];
                    default: ;
                endcase
            end
            if (clr_req) m_pending = 0;
            if (hit && !m_hit_prev) m_pending = 1;
            m_hit_prev = hit;
            m_count = cnt_new;
            m_dv  = hsel && htrans[1];
            m_dw  = m_dv && hwrite;
            m_dsz = m_dv && (hsize == 3'b010);
            m_di  = m_dv ? int'(haddr[4:2]) : 0;
        end
    end

    function automatic logic [31:0] model_rdata();
        if (!m_dv || m_dw) return 32'h0;
        case (m_di)
            0: return {16'h0, m_presc, 6'h0, m_irq_en, m_en};
            1: return m_count[31:0];
            2: return m_shadow;
            3: return m_cmp[31:0];
            4: return m_cmp[63:32];
            5: return {31'h0, m_pending};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            checks++;
            if (hrdata !== model_rdata()) begin
                errors++;
                $display("FAIL hrdata t=%0t idx=%0d got %h want %h", $time, m_di, hrdata, model_rdata());
            end
            checks++;
            if (irq !== (m_pending & m_irq_en)) begin
                errors++;
                $display("FAIL irq t=%0t got %b want %b", $time, irq, m_pending & m_irq_en);
            end
            checks++;
            if (hready !== 1'b1 || hresp !== '0) begin
                errors++;
                $display("FAIL hready_hresp t=%0t got %b/%b want 1/0", $time, hready, hresp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] got, input int lo, input int hi);
        checks++;
        if (got < 32'(lo) || got > 32'(hi)) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic idle_bus();
        hsel = 0; htrans = 2'b00; hwrite = 0;
    endtask

    task automatic addr_phase(input int idx, input bit wr, input logic [2:0] sz);
        hsel = 1; htrans = 2'b10; hwrite = wr; haddr = 32'(idx) << 2; hsize = sz;
        hburst = 0; hprot = 0; hmastlock = 0;
    endtask

    task automatic bus_write(input int idx, input logic [31:0] data, input logic [2:0] sz = 3'b010);
        @(negedge clk); addr_phase(idx, 1, sz);
        @(negedge clk); idle_bus(); hwdata = data;
    endtask

    task automatic bus_read(input int idx, output logic [31:0] data);
        @(negedge clk); addr_phase(idx, 0, 3'b010);
        @(negedge clk); idle_bus(); data = hrdata[31:0];
    endtask

    task automatic write_then_read(input int widx, input logic [31:0] wdata, input int ridx,
                                   output logic [31:0] data);
        @(negedge clk); addr_phase(widx, 1, 3'b010);
        @(negedge clk); hwdata = wdata; addr_phase(ridx, 0, 3'b010);
        @(negedge clk); idle_bus(); data = hrdata[31:0];
    endtask

    task automatic do_reset();
        @(negedge clk); idle_bus(); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    function automatic logic [31:0] gen_data(input int idx);
        case (idx)
            0: return {16'h0, 8'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
            1: return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom_range(0, 300));
            2: return ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1));
            3: return 32'($urandom_range(0, 300));
            4: return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, lo, hi;
        int rises, last_idx, r;
        bit prev_irq, seen;

        reset = 1; hwdata = 0; haddr = 0; hsize = 3'b010; hburst = 0; hprot = 0; hmastlock = 0;
        idle_bus();
        repeat (2) @(negedge clk);
        reset = 0;

        // Reset values of every offset
        bus_read(0, d); check("rst_ctrl", d, 32'h0);
        bus_read(1, d); check("rst_count_lo", d, 32'h0);
        bus_read(2, d); check("rst_count_hi", d, 32'h0);
        bus_read(3, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
        bus_read(4, d); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
        bus_read(5, d); check("rst_status", d, 32'h0);
        bus_read(6, d); check("rst_off18", d, 32'h0);
        bus_read(7, d); check("rst_off1c", d, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // Prescale 3: one count per four cycles
        do_reset();
        bus_write(0, 32'h0000_0301);
        repeat (40) @(negedge clk);
        bus_read(1, d); check_range("presc3_count", d, 9, 11);
        bus_read(0, d); check("presc3_ctrl", d, 32'h0000_0301);

        // Carry into the high word and HI shadow coherence
        do_reset();
        bus_write(1, 32'hFFFF_FFFE);
        bus_write(2, 32'h0);
        bus_write(0, 32'h1);
        repeat (3) @(negedge clk);
        bus_read(1, lo);
        bus_read(2, hi);
        check("shadow_hi", hi, 32'h1);
        check_range("shadow_lo", lo, 1, 16);

        // Compare match raises irq exactly once; W1C drops it for good
        do_reset();
        bus_write(3, 32'd100);
        bus_write(4, 32'd0);
        bus_write(0, 32'h3);
        rises = 0; prev_irq = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (irq && !prev_irq) rises++;
            prev_irq = irq;
        end
        check("cmp_irq_rises", 32'(rises), 32'd1);
        check("cmp_irq_level", {31'h0, irq}, 32'h1);
        bus_read(5, d); check("cmp_status", d, 32'h1);
        bus_write(5, 32'h1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (irq) seen = 1;
        end
        check("w1c_irq_low", {31'h0, seen}, 32'h0);
        bus_read(5, d); check("w1c_status", d, 32'h0);
        bus_read(1, d); check_range("w1c_count_past", d, 101, 1000);

        // Write wins over a same-cycle tick; halfword write ignored
        do_reset();
        bus_write(0, 32'h1);
        write_then_read(1, 32'h5, 1, d); check("tick_vs_write", d, 32'h5);
        bus_write(0, 32'h0, 3'b001);
        bus_read(0, d); check("halfword_ctrl", d, 32'h1);

        // Reset during a write data phase drops the write
        do_reset();
        @(negedge clk); addr_phase(3, 1, 3'b010);
        @(negedge clk); idle_bus(); hwdata = 32'h5; reset = 1;
        @(negedge clk); reset = 0;
        bus_read(3, d); check("rst_mid_cmp_lo", d, 32'hFFFF_FFFF);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);

        // Random back-to-back traffic checked cycle by cycle against the model
        do_reset();
        last_idx = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 699) == 0);
            hwdata = gen_data(last_idx);
            r = $urandom_range(0, 9);
            if (r < 7) begin
                last_idx = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                addr_phase(last_idx, 1'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010);
                hsel = ($urandom_range(0, 9) != 0);
                htrans = 2'($urandom_range(0, 3));
                hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
                haddr[1:0] = 2'($urandom);
                haddr[31:5] = 27'($urandom);
            end else begin
                idle_bus();
                htrans = 2'($urandom_range(0, 1));
                hsel = 1'($urandom);
            end
        end
        @(negedge clk); idle_bus(); reset = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
